// File: rtl/quadtree_switch_allocator.sv
// ---------------------------------------------------------------------------
// quadtree_switch_allocator
//
// Purpose:
//   Switch allocator for one quadtree router. Five input units (children 0-3,
//   parent/local on index 4) each present a head flit and a one-hot or
//   multicast route vector. A flit is granted only when every output it
//   targets is free of foreign wormhole locks, unclaimed by a higher-priority
//   input this cycle, and has downstream credit. This makes multicast moves
//   atomic. Round-robin priority starts at rr_ptr. Locks are held from head
//   to tail, and credits are tracked per output. Allocation is combinational
//   (zero-cycle latency). All state updates on the rising clock edge.
//
// Ports:
//   clk             clock
//   rst_n           asynchronous active-low reset
//   in_valid[i]     input i has a flit at the head of its buffer
//   in_tail[i]      that flit is the last of its packet
//   in_req          route vector of input i at [i*NUM_PORT +: NUM_PORT]
//   out_credit_inc  downstream of output o freed one slot this cycle
//   in_grant[i]     input i's flit moves this cycle (dequeue strobe)
//   out_valid[o]    output o drives a flit this cycle
//   xbar_sel        source input of output o at [o*SEL_WIDTH +: SEL_WIDTH]
//   credit_err      sticky credit overflow flag
//
// Configuration macro:
//   SWITCH_ALLOC_CREDIT_CHECK_EN - when defined, credit_err latches any
//   credit return to an output that is already at full credit. When the
//   macro is undefined, credit_err is tied to 0.
// ---------------------------------------------------------------------------
module quadtree_switch_allocator #(
    parameter int NUM_PORT     = 5,
    parameter int SEL_WIDTH    = 3,
    parameter int CREDIT_WIDTH = 3,
    parameter int CREDIT_INIT  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORT-1:0]           in_valid,
    input  logic [NUM_PORT-1:0]           in_tail,
    input  logic [NUM_PORT*NUM_PORT-1:0]  in_req,
    input  logic [NUM_PORT-1:0]           out_credit_inc,
    output logic [NUM_PORT-1:0]           in_grant,
    output logic [NUM_PORT-1:0]           out_valid,
    output logic [NUM_PORT*SEL_WIDTH-1:0] xbar_sel,
    output logic                          credit_err
);

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(CREDIT_INIT);
    localparam logic [SEL_WIDTH-1:0]    LAST_PORT   = SEL_WIDTH'(NUM_PORT - 1);

    logic [NUM_PORT-1:0]                   lock_valid;
    logic [NUM_PORT-1:0][SEL_WIDTH-1:0]    lock_idx;
    logic [NUM_PORT-1:0][NUM_PORT-1:0]     lock_set;
    logic [NUM_PORT-1:0][CREDIT_WIDTH-1:0] credit;
    logic [SEL_WIDTH-1:0]                  rr_ptr;

    logic [NUM_PORT-1:0][NUM_PORT-1:0]     eff_req;
    logic [NUM_PORT-1:0]                   blocked;
    logic [NUM_PORT-1:0]                   claimed;
    logic                                  any_grant;
    logic [SEL_WIDTH-1:0]                  first_idx;
    logic [SEL_WIDTH-1:0]                  rr_next;
    int                                    alloc_idx;

    // An input holding locks keeps its locked outputs as its request and
    // ignores its routing computer. Any locked-by-another or creditless
    // target output blocks the whole flit.
    always_comb begin
        for (int i = 0; i < NUM_PORT; i++) begin
            eff_req[i] = (lock_set[i] != '0) ? lock_set[i] : in_req[i*NUM_PORT +: NUM_PORT];
            blocked[i] = 1'b0;
            for (int o = 0; o < NUM_PORT; o++) begin
                if (eff_req[i][o]) begin
                    if (credit[o] == '0) begin
                        blocked[i] = 1'b1;
                    end
                    if (lock_valid[o] && (lock_idx[o] != SEL_WIDTH'(i))) begin
                        blocked[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Greedy allocation in round-robin order starting at rr_ptr. An input
    // with an empty route claims nothing but is still granted, so its flit
    // is dropped. Everything is gated by rst_n so outputs stay quiet during
    // reset.
    always_comb begin
        in_grant  = '0;
        claimed   = '0;
        xbar_sel  = '0;
        any_grant = 1'b0;
        first_idx = '0;
        alloc_idx = 0;
        for (int k = 0; k < NUM_PORT; k++) begin
            alloc_idx = int'(rr_ptr) + k;
            if (alloc_idx >= NUM_PORT) begin
                alloc_idx = alloc_idx - NUM_PORT;
            end
            if (rst_n && in_valid[alloc_idx] && !blocked[alloc_idx] &&
                ((eff_req[alloc_idx] & claimed) == '0)) begin
                in_grant[alloc_idx] = 1'b1;
                claimed = claimed | eff_req[alloc_idx];
                for (int o = 0; o < NUM_PORT; o++) begin
                    if (eff_req[alloc_idx][o]) begin
                        xbar_sel[o*SEL_WIDTH +: SEL_WIDTH] = SEL_WIDTH'(alloc_idx);
                    end
                end
                if (!any_grant) begin
                    any_grant = 1'b1;
                    first_idx = SEL_WIDTH'(alloc_idx);
                end
            end
        end
        out_valid = claimed;
        rr_next   = (first_idx == LAST_PORT) ? '0 : first_idx + 1'b1;
    end

    // Lock bookkeeping and round-robin pointer. A non-tail flit from an
    // unlocked input locks its whole route at once, so partial locks never
    // exist. A tail releases everything its input holds. A head+tail flit
    // takes the tail branch and therefore never locks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_valid <= '0;
            lock_idx   <= '0;
            lock_set   <= '0;
            rr_ptr     <= '0;
        end else begin
            if (any_grant) begin
                rr_ptr <= rr_next;
            end
            for (int i = 0; i < NUM_PORT; i++) begin
                if (in_grant[i]) begin
                    if (in_tail[i]) begin
                        lock_set[i] <= '0;
                        for (int o = 0; o < NUM_PORT; o++) begin
                            if (lock_valid[o] && (lock_idx[o] == SEL_WIDTH'(i))) begin
                                lock_valid[o] <= 1'b0;
                            end
                        end
                    end else if (lock_set[i] == '0) begin
                        lock_set[i] <= eff_req[i];
                        for (int o = 0; o < NUM_PORT; o++) begin
                            if (eff_req[i][o]) begin
                                lock_valid[o] <= 1'b1;
                                lock_idx[o]   <= SEL_WIDTH'(i);
                            end
                        end
                    end
                end
            end
        end
    end

    // Per-output credit counters. A send and a return in the same cycle
    // cancel out. A return at full credit saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < NUM_PORT; o++) begin
                credit[o] <= CREDIT_FULL;
            end
        end else begin
            for (int o = 0; o < NUM_PORT; o++) begin
                if (out_valid[o] && !out_credit_inc[o]) begin
                    credit[o] <= credit[o] - 1'b1;
                end else if (!out_valid[o] && out_credit_inc[o] && (credit[o] != CREDIT_FULL)) begin
                    credit[o] <= credit[o] + 1'b1;
                end
            end
        end
    end

`ifdef SWITCH_ALLOC_CREDIT_CHECK_EN
    logic [NUM_PORT-1:0] overflow;

    // A credit return to an output that is already full means the
    // downstream and this router disagree on buffer occupancy.
    always_comb begin
        for (int o = 0; o < NUM_PORT; o++) begin
            overflow[o] = out_credit_inc[o] && !out_valid[o] && (credit[o] == CREDIT_FULL);
        end
    end

    // Sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_err <= 1'b0;
        end else if (overflow != '0) begin
            credit_err <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            for (int o = 0; o < NUM_PORT; o++) begin
                if (overflow[o]) begin
                    $display("quadtree_switch_allocator: credit overflow on output %0d", o);
                end
            end
        end
    end
`endif
`else
    assign credit_err = 1'b0;
`endif

endmodule

// File: tb/tb_quadtree_switch_allocator.sv
// ---------------------------------------------------------------------------
// tb_quadtree_switch_allocator
//
// Directed bench for quadtree_switch_allocator with hand-computed expected
// values. Inputs are driven 1 time unit after the rising edge. Combinational
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_quadtree_switch_allocator;

    logic        clk;
    logic        rst_n;
    logic [4:0]  in_valid;
    logic [4:0]  in_tail;
    logic [24:0] in_req;
    logic [4:0]  out_credit_inc;
    logic [4:0]  in_grant;
    logic [4:0]  out_valid;
    logic [14:0] xbar_sel;
    logic        credit_err;

    int tests;
    int fails;

`ifdef SWITCH_ALLOC_CREDIT_CHECK_EN
    localparam logic [31:0] EXP_ERR = 32'd1;
`else
    localparam logic [31:0] EXP_ERR = 32'd0;
`endif

    quadtree_switch_allocator dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_tail        (in_tail),
        .in_req         (in_req),
        .out_credit_inc (out_credit_inc),
        .in_grant       (in_grant),
        .out_valid      (out_valid),
        .xbar_sel       (xbar_sel),
        .credit_err     (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs, then wait for the falling edge to sample.
    task automatic applyStimulus(input logic [4:0] v, input logic [4:0] t,
                                 input logic [24:0] r, input logic [4:0] inc);
        in_valid       = v;
        in_tail        = t;
        in_req         = r;
        out_credit_inc = inc;
        @(negedge clk);
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAlloc(input string tag, input logic [31:0] g,
                              input logic [31:0] ov, input logic [31:0] xs);
        checkOutput({tag, ".grant"}, 32'(in_grant), g);
        checkOutput({tag, ".out_valid"}, 32'(out_valid), ov);
        checkOutput({tag, ".xbar_sel"}, 32'(xbar_sel), xs);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;

        // Reset state: outputs quiet even with every input requesting.
        applyStimulus(5'b11111, 5'b11111, {5{5'b00001}}, 5'b00000);
        checkAlloc("reset", 32'b0, 32'b0, 32'd0);
        checkOutput("reset.credit_err", 32'(credit_err), 32'd0);
        tick();
        rst_n = 1'b1;

        // Single flit from input 0 to output 2. After the edge, rr_ptr=1 and credit[2]=3.
        applyStimulus(5'b00001, 5'b00001, {20'b0, 5'b00100}, 5'b00000);
        checkAlloc("single", 32'b00001, 32'b00100, 32'd0);
        tick();

        // Inputs 0 and 3 contend for output 4. Credits are refreshed every cycle.
        // rr_ptr=1 lets input 3 win first, then grants alternate.
        for (int c = 0; c < 4; c++) begin
            applyStimulus(5'b01001, 5'b01001, {5'b0, 5'b10000, 5'b0, 5'b0, 5'b10000}, 5'b10000);
            if (c % 2 == 0) checkAlloc("rr_in3", 32'b01000, 32'b10000, 32'd12288);
            else            checkAlloc("rr_in0", 32'b00001, 32'b10000, 32'd0);
            tick();
        end

        // One more input 3 grant moves rr_ptr to 4.
        applyStimulus(5'b01000, 5'b01000, {5'b0, 5'b10000, 15'b0}, 5'b10000);
        checkAlloc("rr_to4", 32'b01000, 32'b10000, 32'd12288);
        tick();

        // Input 4 sends a 3-flit multicast to outputs 0-3 while input 1 wants output 1.
        applyStimulus(5'b10010, 5'b00000, {5'b01111, 10'b0, 5'b00010, 5'b0}, 5'b01111);
        checkAlloc("mc_head", 32'b10000, 32'b01111, 32'd2340);
        tick();
        // The body ignores in_req[4], which follows the held locks.
        applyStimulus(5'b10010, 5'b00000, {5'b00000, 10'b0, 5'b00010, 5'b0}, 5'b01111);
        checkAlloc("mc_body", 32'b10000, 32'b01111, 32'd2340);
        tick();
        applyStimulus(5'b10010, 5'b10000, {5'b00000, 10'b0, 5'b00010, 5'b0}, 5'b01111);
        checkAlloc("mc_tail", 32'b10000, 32'b01111, 32'd2340);
        tick();
        // Locks are released, so input 1 goes. After the edge, credit[1]=3 and rr_ptr=2.
        applyStimulus(5'b00010, 5'b00010, {15'b0, 5'b00010, 5'b0}, 5'b00000);
        checkAlloc("after_mc", 32'b00010, 32'b00010, 32'd8);
        tick();

        // Drain output 2 from credit 3 to 0 with single flits from input 0.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(5'b00001, 5'b00001, {20'b0, 5'b00100}, 5'b00000);
            checkAlloc("drain", 32'b00001, 32'b00100, 32'd0);
            tick();
        end
        applyStimulus(5'b00001, 5'b00001, {20'b0, 5'b00100}, 5'b00000);
        checkAlloc("no_credit", 32'b0, 32'b0, 32'd0);
        tick();
        // The credit returns this cycle and is usable on the next cycle.
        applyStimulus(5'b00001, 5'b00001, {20'b0, 5'b00100}, 5'b00100);
        checkAlloc("credit_ret", 32'b0, 32'b0, 32'd0);
        tick();
        applyStimulus(5'b00001, 5'b00001, {20'b0, 5'b00100}, 5'b00000);
        checkAlloc("regrant", 32'b00001, 32'b00100, 32'd0);
        tick();

        // Empty route on input 2 is granted and dropped. After the edge, rr_ptr=3.
        applyStimulus(5'b00100, 5'b00100, 25'b0, 5'b00000);
        checkAlloc("empty_route", 32'b00100, 32'b0, 32'd0);
        tick();

        // Input 3 head flit locks output 0.
        applyStimulus(5'b01000, 5'b00000, {5'b0, 5'b00001, 15'b0}, 5'b00000);
        checkAlloc("lock_head", 32'b01000, 32'b00001, 32'd3);
        tick();
        applyStimulus(5'b00001, 5'b00001, {20'b0, 5'b00001}, 5'b00000);
        checkAlloc("locked_out", 32'b0, 32'b0, 32'd0);

        // Asynchronous reset mid-packet.
        #2;
        rst_n = 1'b0;
        #1;
        checkAlloc("mid_reset", 32'b0, 32'b0, 32'd0);
        tick();
        rst_n = 1'b1;
        // The lock on output 0 is gone.
        applyStimulus(5'b00001, 5'b00001, {20'b0, 5'b00001}, 5'b00000);
        checkAlloc("post_reset", 32'b00001, 32'b00001, 32'd0);
        tick();
        // Output 2 is back at 4 credits: four grants, then blocked.
        for (int c = 0; c < 4; c++) begin
            applyStimulus(5'b00001, 5'b00001, {20'b0, 5'b00100}, 5'b00000);
            checkAlloc("refill", 32'b00001, 32'b00100, 32'd0);
            tick();
        end
        applyStimulus(5'b00001, 5'b00001, {20'b0, 5'b00100}, 5'b00000);
        checkAlloc("refill_empty", 32'b0, 32'b0, 32'd0);
        tick();

        // Credit return to output 1 while already full.
        applyStimulus(5'b00000, 5'b00000, 25'b0, 5'b00010);
        checkOutput("err_before", 32'(credit_err), 32'd0);
        tick();
        applyStimulus(5'b00000, 5'b00000, 25'b0, 5'b00000);
        checkOutput("err_set", 32'(credit_err), EXP_ERR);
        tick();
        applyStimulus(5'b00000, 5'b00000, 25'b0, 5'b00000);
        checkOutput("err_sticky", 32'(credit_err), EXP_ERR);
        rst_n = 1'b0;
        #1;
        checkOutput("err_reset", 32'(credit_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
